// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared definitions for the lookup-side packet arbiter, the AXI-Stream mux and the packet-state tracker.
package pkt_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd1,
      ST_BUSY = 2'd2
   } arb_state_t;

   localparam int DEFAULT_NUM_QUEUES = 5;
   localparam int DEFAULT_CPU_QUEUE  = 4;

   // Source-port codes carried with each packet; MAC ports are even, CPU/DMA ports odd.
   localparam logic [7:0] SRC_PORT_MAC0 = 8'h00;
   localparam logic [7:0] SRC_PORT_MAC1 = 8'h02;
   localparam logic [7:0] SRC_PORT_MAC2 = 8'h04;
   localparam logic [7:0] SRC_PORT_MAC3 = 8'h06;
   localparam logic [7:0] SRC_PORT_CPU  = 8'h01;

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first request after 'last' with wrap, optional fixed-priority override.
module rr_pick #(
   parameter int N     = 5,
   parameter int SEL_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] last,
   input  logic             cpu_en,
   input  logic [SEL_W-1:0] cpu_idx,
   output logic [N-1:0]     pick_onehot,
   output logic [SEL_W-1:0] pick_idx,
   output logic             any
);

   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] lo_idx;
   logic             hi_hit;
   logic             lo_hit;
   logic             cpu_hit;

   // Descending scan leaves the lowest index in each half; the half above 'last' wins,
   // so 'last' itself is the final candidate.
   always_comb begin
      hi_idx  = '0;
      lo_idx  = '0;
      hi_hit  = 1'b0;
      lo_hit  = 1'b0;
      cpu_hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i > int'(last)) begin
               hi_hit = 1'b1;
               hi_idx = SEL_W'(i);
            end else begin
               lo_hit = 1'b1;
               lo_idx = SEL_W'(i);
            end
            if (cpu_en && (SEL_W'(i) == cpu_idx)) cpu_hit = 1'b1;
         end
      end
      any = |req;
      if (cpu_hit)     pick_idx = cpu_idx;
      else if (hi_hit) pick_idx = hi_idx;
      else             pick_idx = lo_idx;
      pick_onehot = '0;
      for (int i = 0; i < N; i++) pick_onehot[i] = any && (SEL_W'(i) == pick_idx);
   end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: grants one input queue from first word to tlast handshake.
module pkt_rr_arbiter
   import pkt_rr_arbiter_pkg::*;
#(
   parameter int C_NUM_QUEUES    = DEFAULT_NUM_QUEUES,
   parameter int C_SEL_WIDTH     = 3,
   parameter int C_CPU_PRIO      = 0,
   parameter int C_CPU_QUEUE     = DEFAULT_CPU_QUEUE,
   parameter int C_MAX_PKT_WORDS = 200,
   parameter int C_WCNT_WIDTH    = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [C_NUM_QUEUES-1:0] i_req,
   input  logic                    i_tvalid,
   input  logic                    i_tready,
   input  logic                    i_tlast,
   output logic [C_NUM_QUEUES-1:0] o_grant,
   output logic                    o_grant_valid,
   output logic [C_SEL_WIDTH-1:0]  o_sel,
   output logic                    o_sof,
   output logic                    o_oversize
);

   // state   | meaning
   // ST_IDLE | no grant held, arbitrate on any request
   // ST_BUSY | grant held until the tlast handshake

   localparam logic [C_WCNT_WIDTH-1:0] WCNT_SAT = '1;
   localparam logic [C_WCNT_WIDTH-1:0] WCNT_OVS = C_WCNT_WIDTH'(C_MAX_PKT_WORDS);

   arb_state_t              state_q, state_d;
   logic [C_NUM_QUEUES-1:0] grant_q, grant_d;
   logic [C_SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [C_SEL_WIDTH-1:0]  last_q, last_d;
   logic                    first_q, first_d;
   logic [C_WCNT_WIDTH-1:0] wcnt_q, wcnt_d;

   logic                    beat;
   logic                    eop;
   logic                    take;
   logic [C_NUM_QUEUES-1:0] pick_onehot;
   logic [C_SEL_WIDTH-1:0]  pick_idx;
   logic                    pick_any;

   assign beat = i_tvalid & i_tready;
   assign eop  = beat & i_tlast;

   rr_pick #(
      .N     (C_NUM_QUEUES),
      .SEL_W (C_SEL_WIDTH)
   ) u_rr_pick (
      .req         (i_req),
      .last        (last_q),
      .cpu_en      (C_CPU_PRIO != 0),
      .cpu_idx     (C_SEL_WIDTH'(C_CPU_QUEUE)),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .any         (pick_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         last_q  <= C_SEL_WIDTH'(C_NUM_QUEUES - 1);
         first_q <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         first_q <= first_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      last_d  = last_q;
      first_d = first_q;
      wcnt_d  = wcnt_q;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) take = 1'b1;
         end
         ST_BUSY: begin
            if (beat) begin
               first_d = 1'b0;
               if (wcnt_q != WCNT_SAT) wcnt_d = wcnt_q + C_WCNT_WIDTH'(1);
            end
            if (eop) begin
               if (pick_any) begin
                  take = 1'b1;
               end else begin
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      // A new grant on the eop edge overrides the per-beat updates above.
      if (take) begin
         grant_d = pick_onehot;
         sel_d   = pick_idx;
         last_d  = pick_idx;
         first_d = 1'b1;
         wcnt_d  = '0;
         state_d = ST_BUSY;
      end
   end

   assign o_grant       = grant_q;
   assign o_grant_valid = |grant_q;
   assign o_sel         = sel_q;
   assign o_sof         = (state_q == ST_BUSY) & beat & first_q;
   assign o_oversize    = (state_q == ST_BUSY) & beat & (wcnt_q == WCNT_OVS);

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench: expected grant order queued with the stimulus, checked at each start-of-packet.
module tb_pkt_rr_arbiter;

   localparam int NQ  = 5;
   localparam int SW  = 3;
   localparam int MAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NQ-1:0] i_req;
   logic          i_tvalid, i_tready, i_tlast;
   logic [NQ-1:0] o_grant, c_grant;
   logic          o_grant_valid, c_grant_valid;
   logic [SW-1:0] o_sel, c_sel;
   logic          o_sof, c_sof;
   logic          o_oversize, c_oversize;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];
   int exp_cpu_q[$];
   bit mon_cpu = 1'b0;

   always #5 clk = ~clk;

   pkt_rr_arbiter #(
      .C_NUM_QUEUES(NQ), .C_SEL_WIDTH(SW), .C_CPU_PRIO(0), .C_CPU_QUEUE(4),
      .C_MAX_PKT_WORDS(MAX), .C_WCNT_WIDTH(12)
   ) u_dut (
      .clk(clk), .reset(reset), .i_req(i_req), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .i_tlast(i_tlast), .o_grant(o_grant), .o_grant_valid(o_grant_valid), .o_sel(o_sel),
      .o_sof(o_sof), .o_oversize(o_oversize)
   );

   pkt_rr_arbiter #(
      .C_NUM_QUEUES(NQ), .C_SEL_WIDTH(SW), .C_CPU_PRIO(1), .C_CPU_QUEUE(4),
      .C_MAX_PKT_WORDS(MAX), .C_WCNT_WIDTH(12)
   ) u_cpu (
      .clk(clk), .reset(reset), .i_req(i_req), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .i_tlast(i_tlast), .o_grant(c_grant), .o_grant_valid(c_grant_valid), .o_sel(c_sel),
      .o_sof(c_sof), .o_oversize(c_oversize)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every start-of-packet consumes one expected grant index.
   always @(negedge clk) begin
      int e;
      if (o_sof) begin
         if (exp_q.size() == 0) chk("sb_unexpected_sof", 32'(o_sel), 32'hffff_ffff);
         else begin
            e = exp_q.pop_front();
            chk("sb_sel", 32'(o_sel), 32'(e));
            chk("sb_grant", 32'(o_grant), 32'(1) << e);
         end
      end
      if (mon_cpu && c_sof) begin
         if (exp_cpu_q.size() == 0) chk("sb_cpu_unexpected_sof", 32'(c_sel), 32'hffff_ffff);
         else begin
            e = exp_cpu_q.pop_front();
            chk("sb_cpu_sel", 32'(c_sel), 32'(e));
            chk("sb_cpu_grant", 32'(c_grant), 32'(1) << e);
         end
      end
   end

   task automatic do_reset();
      i_req    = '0;
      i_tvalid = 1'b0;
      i_tready = 1'b1;
      i_tlast  = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input int sel_exp);
      @(negedge clk);
      chk({tag, "_grant"}, 32'(o_grant), 32'(0));
      chk({tag, "_gvalid"}, 32'(o_grant_valid), 32'(0));
      chk({tag, "_sel"}, 32'(o_sel), 32'(sel_exp));
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; drives one packet once a grant is present.
   task automatic send_pkt(input int nwords, input bit toggle, input logic [NQ-1:0] req_after,
                           input bit no_bubble);
      int  beats = 0;
      int  cyc   = 0;
      int  t     = 0;
      bit  hs;
      if (no_bubble) chk("no_bubble", 32'(o_grant_valid), 32'(1));
      while (!o_grant_valid && t < 20) begin
         i_tvalid = 1'b0;
         @(posedge clk);
         #1;
         t++;
      end
      if (!o_grant_valid) begin
         chk("grant_timeout", 32'(o_grant_valid), 32'(1));
         return;
      end
      while (beats < nwords && cyc < 64) begin
         i_tvalid = 1'b1;
         i_tready = toggle ? (cyc % 2 == 0) : 1'b1;
         i_tlast  = (beats == nwords - 1);
         hs       = i_tready;
         @(negedge clk);
         chk("grant_held", 32'(o_grant_valid), 32'(1));
         chk("sof", 32'(o_sof), 32'(hs && beats == 0));
         chk("oversize", 32'(o_oversize), 32'(hs && beats == MAX));
         @(posedge clk);
         #1;
         if (hs) begin
            beats++;
            if (beats == 1) i_req = req_after;
         end
         cyc++;
      end
      if (beats < nwords) chk("pkt_timeout", 32'(beats), 32'(nwords));
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      i_tready = 1'b1;
   endtask

   initial begin
      // Reset state and single-queue 3-word packet.
      do_reset();
      @(negedge clk);
      chk("rst_grant", 32'(o_grant), 32'(0));
      chk("rst_gvalid", 32'(o_grant_valid), 32'(0));
      chk("rst_sel", 32'(o_sel), 32'(0));
      chk("rst_sof", 32'(o_sof), 32'(0));
      chk("rst_ovs", 32'(o_oversize), 32'(0));
      @(posedge clk);
      #1 i_req = 5'b00001;
      @(posedge clk);
      @(negedge clk);
      chk("t1_lat_grant", 32'(o_grant), 32'(5'b00001));
      chk("t1_lat_sel", 32'(o_sel), 32'(0));
      @(posedge clk);
      #1;
      exp_q.push_back(0);
      send_pkt(3, 1'b0, 5'b00000, 1'b0);
      chk_idle("t1_after_eop", 0);

      // All queues requesting: zero-bubble rotation 0..4,0.
      do_reset();
      i_req = 5'b11111;
      foreach (exp_q[i]) ;
      for (int i = 0; i < 6; i++) exp_q.push_back(i % NQ);
      for (int i = 0; i < 6; i++) send_pkt(2, 1'b0, (i == 5) ? 5'b00000 : 5'b11111, i != 0);
      chk_idle("t2_after", 0);

      // Requester drops mid-packet with throttled tready; grant held, then queue 2.
      do_reset();
      i_req = 5'b00110;
      exp_q.push_back(1);
      exp_q.push_back(2);
      send_pkt(4, 1'b1, 5'b00100, 1'b0);
      send_pkt(2, 1'b1, 5'b00000, 1'b1);
      chk_idle("t3_after", 2);

      // Same request pattern on fair and CPU-priority arbiters.
      do_reset();
      mon_cpu = 1'b1;
      i_req = 5'b10011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(0);
      for (int i = 0; i < 4; i++) exp_cpu_q.push_back(4);
      for (int i = 0; i < 4; i++) send_pkt(2, 1'b0, (i == 3) ? 5'b00000 : 5'b10011, i != 0);
      chk_idle("t4_after", 0);
      mon_cpu = 1'b0;
      chk("t4_cpu_sb_drained", 32'(exp_cpu_q.size()), 32'(0));

      // Oversize pulse on beat MAX+1, release only after tlast.
      do_reset();
      i_req = 5'b00100;
      exp_q.push_back(2);
      send_pkt(6, 1'b0, 5'b00000, 1'b0);
      chk_idle("t5_after", 2);

      // Reset during word 2; pointer must return to the last queue.
      do_reset();
      i_req = 5'b00010;
      exp_q.push_back(1);
      @(posedge clk);
      #1;
      chk("t6_grant1", 32'(o_sel), 32'(1));
      i_tvalid = 1'b1;
      i_tready = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      i_tvalid = 1'b0;
      i_req    = 5'b00000;
      @(negedge clk);
      chk("t6_rst_grant", 32'(o_grant), 32'(0));
      chk("t6_rst_sel", 32'(o_sel), 32'(0));
      chk("t6_rst_sof", 32'(o_sof), 32'(0));
      @(posedge clk);
      #1 i_req = 5'b01001;
      exp_q.push_back(0);
      exp_q.push_back(3);
      @(posedge clk);
      @(negedge clk);
      chk("t6_ptr_restored", 32'(o_sel), 32'(0));
      @(posedge clk);
      #1;
      send_pkt(1, 1'b0, 5'b01001, 1'b0);
      i_req = 5'b00000;
      send_pkt(1, 1'b0, 5'b00000, 1'b1);
      chk_idle("t6_after", 3);

      chk("sb_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
